// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key codes
// and the row/column to key-code layout.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  localparam logic [3:0] KEY_A    = 4'd10;
  localparam logic [3:0] KEY_B    = 4'd11;
  localparam logic [3:0] KEY_C    = 4'd12;
  localparam logic [3:0] KEY_D    = 4'd13;
  localparam logic [3:0] KEY_STAR = 4'd14;
  localparam logic [3:0] KEY_HASH = 4'd15;

  // Layout: r0 "1 2 3 A", r1 "4 5 6 B", r2 "7 8 9 C", r3 "* 0 # D".
  function automatic logic [3:0] code(input logic [1:0] row_idx, input logic [1:0] col_idx);
    logic [3:0] k;
    case ({row_idx, col_idx})
      4'h0:    k = 4'd1;
      4'h1:    k = 4'd2;
      4'h2:    k = 4'd3;
      4'h3:    k = KEY_A;
      4'h4:    k = 4'd4;
      4'h5:    k = 4'd5;
      4'h6:    k = 4'd6;
      4'h7:    k = KEY_B;
      4'h8:    k = 4'd7;
      4'h9:    k = 4'd8;
      4'hA:    k = 4'd9;
      4'hB:    k = KEY_C;
      4'hC:    k = KEY_STAR;
      4'hD:    k = 4'd0;
      4'hE:    k = KEY_HASH;
      4'hF:    k = KEY_D;
      default: k = 4'd0;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; resets to all ones so an
// idle, pulled-up line reads as released.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_r;
  logic [WIDTH-1:0] sync_r;

  // Metastability chain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_r <= {WIDTH{1'b1}};
      sync_r <= {WIDTH{1'b1}};
    end else begin
      meta_r <= d;
      sync_r <= meta_r;
    end
  end

  assign q = sync_r;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates the column drive, debounces a single
// key press and its release, and emits one code strobe per accepted press.
module keypad_scanner #(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);
  import keypad_pkg::*;

  localparam int MAX_P = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
  localparam int CNT_W = $clog2(MAX_P) + 1;
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Exactly one row low gives {1, index}; idle or multi-key patterns give 0.
  function automatic logic [2:0] row_decode(input logic [3:0] r);
    logic [2:0] d;
    case (r)
      4'b1110: d = {1'b1, 2'd0};
      4'b1101: d = {1'b1, 2'd1};
      4'b1011: d = {1'b1, 2'd2};
      4'b0111: d = {1'b1, 2'd3};
      default: d = 3'b000;
    endcase
    return d;
  endfunction

  logic [3:0]       row_s;
  logic             row_hit_s;
  logic [1:0]       row_idx_s;
  state_t           state_r, state_s;
  logic [1:0]       col_idx_r, col_idx_s;
  logic [3:0]       col_r, col_s;
  logic [CNT_W-1:0] div_r, div_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [3:0]       cap_row_r, cap_row_s;
  logic [3:0]       key_r, key_s;
  logic             key_valid_r, key_valid_s;
  logic             key_held_r, key_held_s;

  sync_2ff #(.WIDTH(4)) u_row_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (row),
    .q     (row_s)
  );

  assign {row_hit_s, row_idx_s} = row_decode(row_s);

  // Next-state and output decisions for the scan/debounce FSM.
  always_comb begin
    state_s     = state_r;
    col_idx_s   = col_idx_r;
    col_s       = col_r;
    div_s       = div_r;
    cnt_s       = cnt_r;
    cap_row_s   = cap_row_r;
    key_s       = key_r;
    key_valid_s = 1'b0;
    key_held_s  = key_held_r;
    case (state_r)
      SCAN: begin
        if (div_r == DIV_LAST) begin
          div_s = CNT_ZERO;
          if (row_hit_s) begin
            cap_row_s = row_s;
            cnt_s     = CNT_ZERO;
            state_s   = DEBOUNCE;
          end else begin
            col_idx_s = col_idx_r + 2'd1;
            col_s     = {col_r[2:0], col_r[3]};
          end
        end else begin
          div_s = div_r + CNT_ONE;
        end
      end
      DEBOUNCE: begin
        if (row_s != cap_row_r) begin
          state_s   = SCAN;
          col_idx_s = col_idx_r + 2'd1;
          col_s     = {col_r[2:0], col_r[3]};
          div_s     = CNT_ZERO;
          cnt_s     = CNT_ZERO;
        end else if (cnt_r == DEB_LAST) begin
          state_s     = PRESSED;
          key_s       = code(row_idx_s, col_idx_r);
          key_valid_s = 1'b1;
          key_held_s  = 1'b1;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      PRESSED: begin
        if (row_s == 4'hF) begin
          state_s = RELEASE;
          cnt_s   = CNT_ZERO;
        end else begin
          state_s = PRESSED;
        end
      end
      RELEASE: begin
        // A bounce back to a pressed pattern resumes the same press silently.
        if (row_s != 4'hF) begin
          state_s = PRESSED;
        end else if (cnt_r == DEB_LAST) begin
          state_s    = SCAN;
          key_held_s = 1'b0;
          col_idx_s  = col_idx_r + 2'd1;
          col_s      = {col_r[2:0], col_r[3]};
          div_s      = CNT_ZERO;
          cnt_s      = CNT_ZERO;
        end else begin
          cnt_s = cnt_r + CNT_ONE;
        end
      end
      default: begin
        state_s = SCAN;
      end
    endcase
  end

  // State, counters and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= SCAN;
      col_idx_r   <= 2'd0;
      col_r       <= 4'b1110;
      div_r       <= CNT_ZERO;
      cnt_r       <= CNT_ZERO;
      cap_row_r   <= 4'hF;
      key_r       <= 4'd0;
      key_valid_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      col_idx_r   <= col_idx_s;
      col_r       <= col_s;
      div_r       <= div_s;
      cnt_r       <= cnt_s;
      cap_row_r   <= cap_row_s;
      key_r       <= key_s;
      key_valid_r <= key_valid_s;
      key_held_r  <= key_held_s;
    end
  end

  assign col       = col_r;
  assign key       = key_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;

endmodule
